// File: rtl/note_sequencer.sv
// note_sequencer: steps a song held in a synchronous ROM and drives the tone decoder's note index.
// Define NOTE_GAP_EN to insert a GAP_CLKS-cycle silence after every note.

module note_sequencer #(
  parameter int AW       = 8,
  parameter int GAP_CLKS = 4096
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          BEAT,
  input  logic          START,
  input  logic          STOP,
  input  logic          PAUSE,
  input  logic          LOOP,
  input  logic [7:0]    ROM_Q,
  output logic [AW-1:0] ROM_ADDR,
  output logic [3:0]    INX,
  output logic          PLAYING,
  output logic          NOTE_STB,
  output logic          DONE
);

  generate
    if (GAP_CLKS < 1) begin : gen_gapCheck
      $error("note_sequencer: GAP_CLKS must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_READ,
    S_PLAY
`ifdef NOTE_GAP_EN
    , S_GAP
`endif
  } state_t;

  state_t        state_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    inx_q;
  logic [3:0]    beatCnt_q;
  logic          noteStb_q;
  logic          done_q;
  logic [3:0]    romNote;
  logic [3:0]    romDur;
  logic          mute;

  assign romNote = ROM_Q[3:0];
  assign romDur  = ROM_Q[7:4];

  // The stored note survives a pause or gap; only the visible index is forced to silence.
`ifdef NOTE_GAP_EN
  localparam int GapW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  logic [GapW-1:0] gapCnt_q;
  assign mute = ((state_q == S_PLAY) && PAUSE) || (state_q == S_GAP);
`else
  assign mute = (state_q == S_PLAY) && PAUSE;
`endif

  assign ROM_ADDR = addr_q;
  assign INX      = mute ? 4'd0 : inx_q;
  assign PLAYING  = (state_q != S_IDLE);
  assign NOTE_STB = noteStb_q;
  assign DONE     = done_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      inx_q     <= 4'd0;
      beatCnt_q <= 4'd0;
      noteStb_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef NOTE_GAP_EN
      gapCnt_q  <= '0;
`endif
    end else begin
      noteStb_q <= 1'b0;
      done_q    <= 1'b0;
      // STOP outranks START, so a simultaneous pair leaves the sequencer idle.
      if (STOP) begin
        state_q   <= S_IDLE;
        addr_q    <= '0;
        inx_q     <= 4'd0;
        beatCnt_q <= 4'd0;
      end else if (START) begin
        state_q <= S_ADDR;
        addr_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            inx_q <= 4'd0;
          end
          S_ADDR: begin
            state_q <= S_READ;
          end
          S_READ: begin
            if (romDur == 4'd0) begin
              addr_q <= '0;
              if (LOOP) begin
                state_q <= S_ADDR;
              end else begin
                state_q <= S_IDLE;
                inx_q   <= 4'd0;
                done_q  <= 1'b1;
              end
            end else begin
              inx_q     <= romNote;
              beatCnt_q <= romDur;
              noteStb_q <= 1'b1;
              state_q   <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (BEAT && !PAUSE) begin
              beatCnt_q <= beatCnt_q - 4'd1;
              if (beatCnt_q == 4'd1) begin
                addr_q <= addr_q + AW'(1);
`ifdef NOTE_GAP_EN
                gapCnt_q <= GapW'(GAP_CLKS - 1);
                state_q  <= S_GAP;
`else
                state_q  <= S_ADDR;
`endif
              end
            end
          end
`ifdef NOTE_GAP_EN
          S_GAP: begin
            if (gapCnt_q == '0) begin
              state_q <= S_ADDR;
            end else begin
              gapCnt_q <= gapCnt_q - GapW'(1);
            end
          end
`endif
          default: begin
            state_q <= S_IDLE;
            inx_q   <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Song-playback controller that drives the 4-bit note index (INX) of the tone decoder, which maps that index to the divider preset, display code and high-octave flag.
- Steps through a song stored in an external synchronous ROM. Holds each note for a programmed number of beat ticks.
- Handles start, stop, pause and loop.
- Sits between the beat-tick divider / user keys and the tone decoder + speaker divider chain.

Parameters:
- AW, 8: ROM address width; the song is up to 2^AW words.
- GAP_CLKS, 4096: articulation-gap length in CLK cycles. Used only when NOTE_GAP_EN is defined. Must be >= 1.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-high reset.
- BEAT  in  1  one-CLK-wide beat enable from the beat divider (e.g. 4 Hz).
- START  in  1  one-CLK pulse: begin playback from address 0.
- STOP  in  1  one-CLK pulse: abort playback.
- PAUSE  in  1  level: freeze playback and silence output.
- LOOP  in  1  level: on end marker, restart at address 0 instead of finishing.
- ROM_Q  in  8  ROM data. [3:0] = note index (0 = rest); [7:4] = duration in beats (0 = end-of-song marker).
- ROM_ADDR  out  AW  ROM address. The ROM registers the address, so data is valid one CLK after the address.
- INX  out  4  note index to the tone decoder; 0 = silence.
- PLAYING  out  1  high in every state except IDLE.
- NOTE_STB  out  1  one-CLK pulse when a new note is loaded into INX.
- DONE  out  1  one-CLK pulse when the song ends without LOOP.

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE.
  - ROM_ADDR = 0, INX = 0, PLAYING = 0, NOTE_STB = 0, DONE = 0.
  - Internal duration counter = 0.
- States: IDLE, ADDR, READ, PLAY, plus GAP (NOTE_GAP_EN only).
- IDLE:
  - INX = 0.
  - START -> ROM_ADDR <= 0, go to ADDR.
  - BEAT and PAUSE are ignored.
- ADDR: one wait cycle while the ROM registers the address -> READ.
- READ: sample ROM_Q.
  - Duration == 0 (end marker), LOOP = 1: ROM_ADDR <= 0, go to ADDR.
  - Duration == 0, LOOP = 0: DONE pulse, INX <= 0, go to IDLE.
  - Otherwise: INX <= note, counter <= duration, NOTE_STB pulse, go to PLAY.
- Latency: INX updates on the 2nd rising edge after the edge that samples START.
- PLAY (PAUSE = 0):
  - Each BEAT decrements the counter.
  - BEAT with counter == 1: ROM_ADDR <= ROM_ADDR + 1, go to ADDR (or GAP).
  - The first BEAT after load counts, so the hold time lies in (dur-1, dur] beat periods.
- PAUSE = 1 in PLAY:
  - BEAT is ignored and the counter is frozen.
  - INX reads 0 while PAUSE is high.
  - The stored note is restored when PAUSE drops.
  - PAUSE is ignored in ADDR, READ and GAP; it takes effect on the first PLAY cycle.
- During ADDR and READ, INX holds the previous note; there is no glitch to 0.
- Address wrap: ROM_ADDR increments modulo 2^AW. A missing end marker wraps to 0 and playback continues regardless of LOOP.
- Rest note (index 0) with nonzero duration: plays silence for that duration, and NOTE_STB still pulses.
- STOP (any state other than IDLE):
  - Next state = IDLE, INX <= 0, ROM_ADDR <= 0.
  - No DONE pulse.
- START outside IDLE: restart from address 0 (go to ADDR, ROM_ADDR <= 0). The current note holds until the reload.
- START and STOP in the same cycle: STOP wins.
- Reset mid-note: immediate return to reset values; no DONE.

Optional Feature:
- Macro: NOTE_GAP_EN.
- Defined:
  - After a note's final BEAT, enter GAP: INX = 0 for exactly GAP_CLKS cycles, then go to ADDR.
  - This makes repeated identical notes audibly separate.
  - STOP and reset still abort GAP immediately.
- Undefined:
  - GAP state and its counter are absent; PLAY goes straight to ADDR.
  - GAP_CLKS is unused.

Test Plan:
- Reset, then START. ROM = {0x23, 0x15, 0x00}, LOOP = 0, BEAT every 10 CLK.
  - INX = 3 two edges after START, for 2 beats; then INX = 5 for 1 beat.
  - Then DONE pulses once, INX = 0, PLAYING = 0.
- Same ROM with LOOP = 1 -> after the 0x00 word, ROM_ADDR returns to 0 and INX = 3 again with NOTE_STB.
  - DONE never pulses.
- During a 4-beat note 0x47, PAUSE high across 3 BEATs -> INX = 0 and the counter is frozen.
  - After PAUSE drops, the note resumes; it ends after 4 total unpaused BEATs.
- STOP asserted mid-note at address 5, together with START -> IDLE, INX = 0, ROM_ADDR = 0, no DONE.
  - A later START replays from address 0.
- AW = 2, ROM with no end marker, e.g. {0x11, 0x12, 0x13, 0x14} -> addresses 0, 1, 2, 3, 0 in sequence.
  - Playback continues with LOOP = 0.
- NOTE_GAP_EN defined, GAP_CLKS = 8, ROM {0x11, 0x11, 0x00} -> INX = 0 for exactly 8 CLK between the two notes.
  - With the macro undefined: no zero gap; INX stays 1 continuously.
